intersection_scheduler: RTL and testbench
=========================================

# intersection_scheduler

- Sequences a two-road intersection (north-south main road, east-west side road) as one synchronous Moore FSM with a shared phase timer.
- Grants green to exactly one road at a time and inserts yellow and all-red clearance between grants.
- Optionally inserts a pedestrian walk phase.
- Sits above the per-road light drivers; timing is in clock cycles, and the integrator scales the parameters to the clock rate.

## Interface
- `T_GREEN_MIN`, default 8: minimum cycles any green is held.
- `T_GREEN_MAX`, default 32: maximum cycles an east-west green is held under contention.
- `T_YELLOW`, default 3: yellow duration in cycles.
- `T_ALLRED`, default 2: all-red clearance in cycles.
- `T_WALK`, default 6: walk phase duration in cycles (used only with `INTERSECTION_PED_EN`).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset, sampled on the `clk` rising edge.
- `car_ns` in 1: a vehicle is waiting on the north-south road (level).
- `car_ew` in 1: a vehicle is waiting on the east-west road (level).
- `ped_req` in 1: pedestrian button (pulse or level). Ignored without `INTERSECTION_PED_EN`.
- `ns_grn`, `ns_ylw`, `ns_red` out 1 each: north-south lamps, one-hot.
- `ew_grn`, `ew_ylw`, `ew_red` out 1 each: east-west lamps, one-hot.
- `walk` out 1: pedestrian walk lamp. Tied to 0 without the macro.
- `phase` out 3: current state encoding, for debug and the bench.

## Operation
- States:
  - `NS_G`=0, `NS_Y`=1, `AR1`=2 (clearance toward east-west)
  - `EW_G`=3, `EW_Y`=4, `AR2`=5 (clearance toward north-south)
  - `WALK`=6 (macro only)
- Timer `tmr` is 16 bits. It is loaded with duration-1 when a state is entered, decrements each cycle while nonzero, and holds at 0.
- "Expired" means `tmr`==0.
- Demand for east-west: `dem_ew` = `car_ew` | `ped_pend`.
- Transitions:
  - `NS_G` goes to `NS_Y` when expired and `dem_ew`. Otherwise it stays; north-south is the rest state.
  - `NS_Y` goes to `AR1` when expired.
  - `AR1` goes to `WALK` if `ped_pend`, otherwise to `EW_G`, when expired.
  - `EW_G` goes to `EW_Y` when any of these holds:
    - expired at the `T_GREEN_MIN` mark and `car_ew`==0
    - `EW_G` has run `T_GREEN_MAX` cycles total and `car_ns`==1
    - `EW_G` has run `T_GREEN_MAX` cycles total and `ped_pend`==1
  - Otherwise `EW_G` extends one cycle at a time. A second counter `ext`, zeroed on `EW_G` entry, tracks the total.
  - `EW_Y` goes to `AR2` when expired.
  - `AR2` goes to `WALK` if `ped_pend`, otherwise to `NS_G`, when expired.
  - `WALK` goes to `NS_G` if it was entered from `AR2`, or to `EW_G` if entered from `AR1`, when expired. A 1-bit `dest` register records the origin.
- Lamps are decoded combinationally from the state register (Moore):
  - `*_G` states: that road green, the other road red.
  - `*_Y` states: that road yellow, the other road red.
  - `AR1`/`AR2`/`WALK`: both roads red. `walk`=1 only in `WALK`.
- Lamp invariant: both roads are never non-red in the same cycle. An illegal `phase` value decodes to all red and goes to `AR2` on the next edge.

## Timing
- Reset (`rst`=1 at an edge):
  - state: `phase`=`NS_G`, `tmr`=`T_GREEN_MIN`-1, `ext`=0, `ped_pend`=0, `dest`=0.
  - outputs: `ns_grn`=1, `ew_red`=1, all other lamps 0, `walk`=0.
- Reset mid-phase abandons the phase immediately. There is no yellow on reset.
- Phase durations, measured from the entry edge to the exit edge:
  - yellow: exactly `T_YELLOW` cycles
  - all-red: exactly `T_ALLRED` cycles
  - walk: exactly `T_WALK` cycles
  - green: at least `T_GREEN_MIN` cycles
- East-west green is at most `T_GREEN_MAX` cycles only when north-south or pedestrian demand exists. It is unbounded if `car_ns`=0 and `ped_pend`=0.
- Inputs are sampled at the rising edge. There is 1 cycle from the demand edge to the lamp change when the timer is already expired.
- `ped_pend`:
  - Set on any cycle with `ped_req`=1.
  - Cleared on the edge entering `WALK`.
  - If set and clear coincide, set wins, so a request arriving during `WALK` entry is kept for the next cycle of the sequence.
- Simultaneous `car_ns` and `car_ew` in `NS_G`: leaves after min green (east-west is served).
- Parameter rules: all parameters ≥1, `T_GREEN_MAX` ≥ `T_GREEN_MIN`, all < 2^16. Violations are caught by an elaboration-time check.

## Configuration
- `INTERSECTION_PED_EN` defined:
  - `ped_req`, `ped_pend`, `dest` and the `WALK` state are present.
  - `ped_pend` counts as east-west demand.
- `INTERSECTION_PED_EN` undefined:
  - No `WALK` state; `phase`=6 is illegal.
  - `walk` is tied to 0 and `ped_req` is ignored.
  - `dem_ew` = `car_ew`.

## Test plan
Parameters for all scenarios: `T_GREEN_MIN`=4, `T_GREEN_MAX`=8, `T_YELLOW`=2, `T_ALLRED`=1, `T_WALK`=3.
1. Reset, then `car_ew`=0 and `car_ns`=0 for 50 cycles:
   - `ns_grn`=1 and `ew_red`=1 throughout; `phase`=0.
2. `car_ew` pulsed 1 cycle at cycle 10 after reset:
   - `NS_Y` for 2 cycles, then `AR1` for 1, then `EW_G` for exactly 4, then `EW_Y` for 2, then `AR2` for 1, then `NS_G`.
3. `car_ew`=1 held and `car_ns`=1:
   - `EW_G` lasts exactly 8 cycles, then `EW_Y`.
   - With `car_ns`=0 instead, `EW_G` persists while `car_ew`=1.
4. Macro on, `ped_req` pulse in `NS_G` with no cars:
   - Sequence `NS_Y`(2), `AR1`(1), `WALK`(3, `walk`=1, all red), `EW_G`(4), then back toward north-south.
   - `ped_pend`=0 after `WALK` entry.
5. Reset asserted during `EW_Y`:
   - Next cycle `phase`=0 and `ns_grn`=1 with no intermediate lamp states.
6. Random `car`/`ped` stimulus for 10k cycles:
   - Assertion never fires: (`ns_grn`|`ns_ylw`) & (`ew_grn`|`ew_ylw`).
   - Each road's lamps are always one-hot.

Source files
------------

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: two-road traffic light sequencer (Moore FSM, shared phase timer).
// North-south is the rest road; east-west is served on demand with yellow and all-red
// clearance between grants. Optional pedestrian walk phase under `INTERSECTION_PED_EN.
// Lamps are registered from the next-state decode, so they change on the same edge as phase.
module intersection_scheduler #(
  parameter int T_GREEN_MIN = 8,
  parameter int T_GREEN_MAX = 32,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 2,
  parameter int T_WALK      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped_req,
  output logic       ns_grn,
  output logic       ns_ylw,
  output logic       ns_red,
  output logic       ew_grn,
  output logic       ew_ylw,
  output logic       ew_red,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_G = 3'd0, NS_Y = 3'd1, AR1 = 3'd2,
    EW_G = 3'd3, EW_Y = 3'd4, AR2 = 3'd5,
    WALK = 3'd6
  } state_t;

  // Parameter legality is checked once, at elaboration.
  if (T_GREEN_MIN < 1 || T_GREEN_MAX < 1 || T_YELLOW < 1 || T_ALLRED < 1 || T_WALK < 1 ||
      T_GREEN_MAX < T_GREEN_MIN || T_GREEN_MAX > 65535 || T_GREEN_MIN > 65535 ||
      T_YELLOW > 65535 || T_ALLRED > 65535 || T_WALK > 65535) begin : g_param_check
    $error("intersection_scheduler: illegal timing parameters");
  end

  localparam logic [15:0] GMIN_M1 = 16'(T_GREEN_MIN - 1);
  localparam logic [15:0] EXT_LIM = 16'(T_GREEN_MAX - 1);
  localparam logic [15:0] YLW_M1  = 16'(T_YELLOW - 1);
  localparam logic [15:0] AR_M1   = 16'(T_ALLRED - 1);
  localparam logic [15:0] WALK_M1 = 16'(T_WALK - 1);

  state_t      state_r;
  state_t      state_s;
  logic [15:0] tmr_r;
  logic [15:0] ext_r;
  logic        expired_s;
  logic        max_hit_s;
  logic        ped_pend_s;
  logic        dem_ew_s;
  logic        enter_walk_s;

  // Timer reload value for a state: its duration minus one.
  function automatic logic [15:0] dur_m1(input state_t s);
    case (s)
      NS_G, EW_G: dur_m1 = GMIN_M1;
      NS_Y, EW_Y: dur_m1 = YLW_M1;
      AR1, AR2:   dur_m1 = AR_M1;
      WALK:       dur_m1 = WALK_M1;
      default:    dur_m1 = 16'd0;
    endcase
  endfunction

  // Lamp decode {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}; anything unknown is all red.
  function automatic logic [6:0] lamp_decode(input state_t s);
    case (s)
      NS_G:    lamp_decode = 7'b100_001_0;
      NS_Y:    lamp_decode = 7'b010_001_0;
      EW_G:    lamp_decode = 7'b001_100_0;
      EW_Y:    lamp_decode = 7'b001_010_0;
`ifdef INTERSECTION_PED_EN
      WALK:    lamp_decode = 7'b001_001_1;
`endif
      default: lamp_decode = 7'b001_001_0;
    endcase
  endfunction

`ifdef INTERSECTION_PED_EN
  logic ped_pend_r;
  logic dest_r;   // 1: walk returns to east-west green, 0: to north-south green
  assign ped_pend_s = ped_pend_r;
`else
  logic unused_ped_s;
  assign unused_ped_s = ped_req;
  assign ped_pend_s   = 1'b0;
`endif

  assign expired_s    = (tmr_r == 16'd0);
  assign max_hit_s    = (ext_r >= EXT_LIM);
  assign dem_ew_s     = car_ew | ped_pend_s;
  assign enter_walk_s = (state_s == WALK) && (state_r != WALK);

  // Next-state logic for the phase sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      NS_G: if (expired_s && dem_ew_s) state_s = NS_Y; else state_s = NS_G;
      NS_Y: if (expired_s) state_s = AR1; else state_s = NS_Y;
      AR1: begin
        if (expired_s) state_s = ped_pend_s ? WALK : EW_G;
        else           state_s = AR1;
      end
      EW_G: begin
        if ((expired_s && !car_ew) || (max_hit_s && (car_ns || ped_pend_s))) state_s = EW_Y;
        else                                                                 state_s = EW_G;
      end
      EW_Y: if (expired_s) state_s = AR2; else state_s = EW_Y;
      AR2: begin
        if (expired_s) state_s = ped_pend_s ? WALK : NS_G;
        else           state_s = AR2;
      end
`ifdef INTERSECTION_PED_EN
      WALK: begin
        if (expired_s) state_s = dest_r ? EW_G : NS_G;
        else           state_s = WALK;
      end
`endif
      default: state_s = AR2;
    endcase
  end

  // State, phase timer, east-west green extension counter and registered lamps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= NS_G;
      tmr_r   <= GMIN_M1;
      ext_r   <= 16'd0;
      {ns_grn, ns_ylw, ns_red, ew_grn, ew_ylw, ew_red, walk} <= lamp_decode(NS_G);
    end else begin
      state_r <= state_s;
      if (state_s != state_r)   tmr_r <= dur_m1(state_s);
      else if (!expired_s)      tmr_r <= tmr_r - 16'd1;
      else                      tmr_r <= tmr_r;
      if (state_s != state_r)                        ext_r <= 16'd0;
      else if (state_r == EW_G && ext_r != 16'hFFFF) ext_r <= ext_r + 16'd1;
      else                                           ext_r <= ext_r;
      {ns_grn, ns_ylw, ns_red, ew_grn, ew_ylw, ew_red, walk} <= lamp_decode(state_s);
    end
  end

`ifdef INTERSECTION_PED_EN
  // Pedestrian request latch (set beats clear) and walk return direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      ped_pend_r <= 1'b0;
      dest_r     <= 1'b0;
    end else begin
      if (ped_req)           ped_pend_r <= 1'b1;
      else if (enter_walk_s) ped_pend_r <= 1'b0;
      else                   ped_pend_r <= ped_pend_r;
      if (enter_walk_s)      dest_r <= (state_r == AR1);
      else                   dest_r <= dest_r;
    end
  end
`else
  logic unused_walk_s;
  assign unused_walk_s = enter_walk_s;
`endif

  assign phase = state_r;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Scoreboard bench for intersection_scheduler: the driver steps a phase/age reference
// model and queues the expected phase and lamps; a monitor compares after each edge.
module tb_intersection_scheduler;
  localparam int GMIN = 4, GMAX = 8, TY = 2, TAR = 1, TW = 3;
`ifdef INTERSECTION_PED_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, car_ns = 1'b0, car_ew = 1'b0, ped_req = 1'b0;
  logic ns_grn, ns_ylw, ns_red, ew_grn, ew_ylw, ew_red, walk;
  logic [2:0] phase;

  intersection_scheduler #(
    .T_GREEN_MIN(GMIN), .T_GREEN_MAX(GMAX), .T_YELLOW(TY), .T_ALLRED(TAR), .T_WALK(TW)
  ) dut (
    .clk(clk), .rst(rst), .car_ns(car_ns), .car_ew(car_ew), .ped_req(ped_req),
    .ns_grn(ns_grn), .ns_ylw(ns_ylw), .ns_red(ns_red),
    .ew_grn(ew_grn), .ew_ylw(ew_ylw), .ew_red(ew_red),
    .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ph;
    logic [6:0] lamps;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: phase number, cycles spent in it, pending walk, walk return road.
  int m_phase = 0;
  int m_age   = 1;
  bit m_ped   = 1'b0;
  bit m_dest  = 1'b0;

  function automatic logic [6:0] exp_lamps(input int p);
    case (p)
      0:       return 7'b100_001_0;
      1:       return 7'b010_001_0;
      3:       return 7'b001_100_0;
      4:       return 7'b001_010_0;
      6:       return 7'b001_001_1;
      default: return 7'b001_001_0;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit cns, input bit cew, input bit preq);
    int nxt;
    bit ped_now;
    bit into_walk;
    if (r) begin
      m_phase = 0; m_age = 1; m_ped = 1'b0; m_dest = 1'b0;
      return;
    end
    ped_now = PED && m_ped;
    nxt = m_phase;
    case (m_phase)
      0: if (m_age >= GMIN && (cew || ped_now)) nxt = 1;
      1: if (m_age >= TY) nxt = 2;
      2: if (m_age >= TAR) nxt = ped_now ? 6 : 3;
      3: if ((m_age >= GMIN && !cew) || (m_age >= GMAX && (cns || ped_now))) nxt = 4;
      4: if (m_age >= TY) nxt = 5;
      5: if (m_age >= TAR) nxt = ped_now ? 6 : 0;
      6: if (m_age >= TW) nxt = m_dest ? 3 : 0;
      default: nxt = 5;
    endcase
    into_walk = (nxt == 6) && (m_phase != 6);
    if (into_walk) m_dest = (m_phase == 2);
    if (PED) m_ped = preq || (m_ped && !into_walk);
    m_age = (nxt == m_phase) ? m_age + 1 : 1;
    m_phase = nxt;
  endtask

  task automatic cycle(input bit r, input bit cns, input bit cew, input bit preq);
    exp_t e;
    @(negedge clk);
    rst = r; car_ns = cns; car_ew = cew; ped_req = preq;
    model_step(r, cns, cew, preq);
    e.ph = 3'(m_phase);
    e.lamps = exp_lamps(m_phase);
    q.push_back(e);
  endtask

  // Monitor: one expected entry per clock edge, checked just after the edge.
  initial begin
    exp_t e;
    logic [6:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        act = {ns_grn, ns_ylw, ns_red, ew_grn, ew_ylw, ew_red, walk};
        tests++;
        if (phase !== e.ph) begin
          fails++;
          $display("FAIL phase t=%0t got %0d expected %0d", $time, phase, e.ph);
        end
        tests++;
        if (act !== e.lamps) begin
          fails++;
          $display("FAIL lamps t=%0t got %b expected %b", $time, act, e.lamps);
        end
        tests++;
        if (((ns_grn | ns_ylw) & (ew_grn | ew_ylw)) !== 1'b0) begin
          fails++;
          $display("FAIL conflict t=%0t lamps %b expected no dual non-red", $time, act);
        end
        tests++;
        if ($countones({ns_grn, ns_ylw, ns_red}) != 1 || $countones({ew_grn, ew_ylw, ew_red}) != 1) begin
          fails++;
          $display("FAIL onehot t=%0t lamps %b expected one-hot per road", $time, act);
        end
      end
    end
  end

  initial begin
    int n;
    bit cns, cew;
    // Reset, then idle: north-south rests.
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (50) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    // Single-cycle east-west pulse at cycle 10 after reset.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (20) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    // Contention: east-west green capped at max; then east-west alone holds green.
    repeat (30) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (40) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (20) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    // Pedestrian pulse in north-south green, no cars.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (25) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    // Reset while in east-west yellow.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (m_phase != 4 && n < 100) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    tests++;
    if (m_phase != 4) begin
      fails++;
      $display("FAIL reach_ew_y got phase %0d expected 4 within 100 cycles", m_phase);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    // Random traffic with occasional resets.
    cns = 1'b0; cew = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 15) == 0) cns = ~cns;
      if ($urandom_range(0, 11) == 0) cew = ~cew;
      cycle($urandom_range(0, 499) == 0, cns, cew, $urandom_range(0, 29) == 0);
    end
    // Drain the scoreboard with a bounded wait.
    n = 0;
    while (q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d entries left expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
